// File: rtl/mem_pkg.sv
// Shared constants and FSM state type for the CPU data-memory responder.
package mem_pkg;
  localparam int DATA_W     = 8;
  localparam int DEF_ADDR_W = 17;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_DONE
  } state_t;
endpackage

// File: rtl/dmem_byte_ram.sv
// Byte-wide simple dual-port RAM: synchronous write, registered read, no reset.
module dmem_byte_ram
  import mem_pkg::*;
#(
  parameter int DEPTH = 131072,
  parameter int AW    = 17
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/data_mem_responder.sv
// CPU data-memory responder: accepts one byte read or write at a time, inserts
// WAIT_CYCLES wait states, then completes with a one-cycle done pulse.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DEPTH       = 131072,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              rd_req,
  input  logic              wr_req,
  output logic [DATA_W-1:0] rdata_out,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int         RAM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic                is_write_reg;
  logic                err_reg;
  logic [DATA_W-1:0]   rdata_reg;
  logic                accept, conflict, in_range;
  logic                ram_we;
  logic [RAM_AW-1:0]   ram_raddr;
  logic [DATA_W-1:0]   ram_q;

  assign accept   = (state_reg == ST_IDLE) && (rd_req ^ wr_req);
  assign conflict = (state_reg == ST_IDLE) && rd_req && wr_req;
  assign in_range = (32'(addr_reg) < 32'(DEPTH));

  // In IDLE the RAM looks at the live address so the registered read is ready
  // by ACCESS even with zero wait states.
  assign ram_raddr = (state_reg == ST_IDLE) ? address_in[RAM_AW-1:0]
                                            : addr_reg[RAM_AW-1:0];
  assign ram_we    = (state_reg == ST_ACCESS) && is_write_reg && in_range;

  dmem_byte_ram #(
    .DEPTH (DEPTH),
    .AW    (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (addr_reg[RAM_AW-1:0]),
    .wdata (wdata_reg),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        busy = 1'b0;
        if (conflict) begin
          state_next = ST_DONE;
        end else if (accept) begin
          state_next = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_reg <= 4'd1) begin
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: state_next = ST_DONE;
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg      <= 4'd0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      is_write_reg <= 1'b0;
      err_reg      <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (conflict) begin
            err_reg <= 1'b1;
          end else if (accept) begin
            addr_reg     <= address_in;
            wdata_reg    <= wdata_in;
            is_write_reg <= wr_req;
            cnt_reg      <= WAIT_INIT;
            err_reg      <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ST_ACCESS: begin
          // Out-of-range writes are dropped by ram_we; reads return zero.
          if (!in_range) begin
            err_reg <= 1'b1;
            if (!is_write_reg) begin
              rdata_reg <= '0;
            end
          end else if (!is_write_reg) begin
            rdata_reg <= ram_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdata_out = rdata_reg;
  assign err       = err_reg;
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: three responder instances (different waits/depths)
// exercised by directed scenarios and a randomized run against a byte-map model.
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [16:0] addr_s  [3];
  logic [7:0]  wd_s    [3];
  logic        rd_s    [3];
  logic        wr_s    [3];
  logic [7:0]  rdata_o [3];
  logic        busy_o  [3];
  logic        done_o  [3];
  logic        err_o   [3];
  int n_vec = 0;
  int n_err = 0;
  int wait_k  [3] = '{2, 0, 3};
  int depth_k [3] = '{131072, 131072, 4096};

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(17), .DEPTH(131072), .WAIT_CYCLES(2)) u0 (
    .clk(clk), .rst_n(rst_n), .address_in(addr_s[0]), .wdata_in(wd_s[0]),
    .rd_req(rd_s[0]), .wr_req(wr_s[0]), .rdata_out(rdata_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0]));
  data_mem_responder #(.ADDR_W(17), .DEPTH(131072), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .rst_n(rst_n), .address_in(addr_s[1]), .wdata_in(wd_s[1]),
    .rd_req(rd_s[1]), .wr_req(wr_s[1]), .rdata_out(rdata_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1]));
  data_mem_responder #(.ADDR_W(17), .DEPTH(4096), .WAIT_CYCLES(3)) u2 (
    .clk(clk), .rst_n(rst_n), .address_in(addr_s[2]), .wdata_in(wd_s[2]),
    .rd_req(rd_s[2]), .wr_req(wr_s[2]), .rdata_out(rdata_o[2]),
    .busy(busy_o[2]), .done(done_o[2]), .err(err_o[2]));

  // Issues one request, scrambles the inputs right after acceptance, and
  // reports latency (negedges after accept until done, -1 on timeout).
  task automatic run_op(input int k, input logic rd, input logic wr,
                        input logic [16:0] a, input logic [7:0] d,
                        output int lat, output logic [7:0] q, output logic e,
                        output logic b1, output logic d2);
    int guard = 0;
    @(negedge clk);
    while (busy_o[k] !== 1'b0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    rd_s[k] = rd; wr_s[k] = wr; addr_s[k] = a; wd_s[k] = d;
    @(negedge clk);
    b1 = busy_o[k];
    rd_s[k] = 1'b0; wr_s[k] = 1'b0;
    addr_s[k] = 17'($urandom); wd_s[k] = 8'($urandom);
    lat = 1;
    while (done_o[k] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) lat = -1;
    q = rdata_o[k];
    e = err_o[k];
    @(negedge clk);
    d2 = done_o[k];
    $display("op inst=%0d rd=%0b wr=%0b addr=%h wdata=%h lat=%0d rdata=%h err=%0b",
             k, rd, wr, a, d, lat, q, e);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rd_s[k] = 1'b0; wr_s[k] = 1'b0; addr_s[k] = '0; wd_s[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (busy_o[k] !== 1'b0) begin n_err++; $display("FAIL reset_busy inst=%0d got %b exp 0", k, busy_o[k]); end
      n_vec++; if (done_o[k] !== 1'b0) begin n_err++; $display("FAIL reset_done inst=%0d got %b exp 0", k, done_o[k]); end
      n_vec++; if (err_o[k] !== 1'b0) begin n_err++; $display("FAIL reset_err inst=%0d got %b exp 0", k, err_o[k]); end
      n_vec++; if (rdata_o[k] !== 8'h00) begin n_err++; $display("FAIL reset_rdata inst=%0d got %h exp 00", k, rdata_o[k]); end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    int lat; logic [7:0] q; logic e, b1, d2;
    run_op(0, 1'b0, 1'b1, 17'h00123, 8'hA5, lat, q, e, b1, d2);
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL wr_latency got %0d exp 4", lat); end
    n_vec++; if (e !== 1'b0) begin n_err++; $display("FAIL wr_err got %b exp 0", e); end
    n_vec++; if (b1 !== 1'b1) begin n_err++; $display("FAIL wr_busy got %b exp 1", b1); end
    n_vec++; if (d2 !== 1'b0) begin n_err++; $display("FAIL wr_done_width got %b exp 0", d2); end
    n_vec++; if (q !== 8'h00) begin n_err++; $display("FAIL wr_rdata_hold got %h exp 00", q); end
    run_op(0, 1'b1, 1'b0, 17'h00123, 8'h00, lat, q, e, b1, d2);
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL rd_latency got %0d exp 4", lat); end
    n_vec++; if (q !== 8'hA5) begin n_err++; $display("FAIL rd_data got %h exp a5", q); end
    n_vec++; if (e !== 1'b0) begin n_err++; $display("FAIL rd_err got %b exp 0", e); end
  endtask

  task automatic test_zero_wait;
    int lat; logic [7:0] q; logic e, b1, d2;
    run_op(1, 1'b0, 1'b1, 17'h1FFFF, 8'h3C, lat, q, e, b1, d2);
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL w0_wr_latency got %0d exp 2", lat); end
    n_vec++; if (e !== 1'b0) begin n_err++; $display("FAIL w0_wr_err got %b exp 0", e); end
    run_op(1, 1'b1, 1'b0, 17'h1FFFF, 8'h00, lat, q, e, b1, d2);
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL w0_rd_latency got %0d exp 2", lat); end
    n_vec++; if (q !== 8'h3C) begin n_err++; $display("FAIL w0_rd_data got %h exp 3c", q); end
    n_vec++; if (d2 !== 1'b0) begin n_err++; $display("FAIL w0_done_width got %b exp 0", d2); end
  endtask

  task automatic test_conflict;
    int lat; logic [7:0] q; logic e, b1, d2;
    run_op(0, 1'b1, 1'b1, 17'h00123, 8'h00, lat, q, e, b1, d2);
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL conf_latency got %0d exp 1", lat); end
    n_vec++; if (e !== 1'b1) begin n_err++; $display("FAIL conf_err got %b exp 1", e); end
    n_vec++; if (q !== 8'hA5) begin n_err++; $display("FAIL conf_rdata got %h exp a5", q); end
    n_vec++; if (d2 !== 1'b0) begin n_err++; $display("FAIL conf_done_width got %b exp 0", d2); end
    run_op(0, 1'b1, 1'b0, 17'h00123, 8'h00, lat, q, e, b1, d2);
    n_vec++; if (e !== 1'b0) begin n_err++; $display("FAIL conf_err_clear got %b exp 0", e); end
    n_vec++; if (q !== 8'hA5) begin n_err++; $display("FAIL conf_ram_kept got %h exp a5", q); end
  endtask

  task automatic test_out_of_range;
    int lat; logic [7:0] q; logic e, b1, d2;
    run_op(2, 1'b0, 1'b1, 17'h00000, 8'h5A, lat, q, e, b1, d2);
    n_vec++; if (lat !== 5) begin n_err++; $display("FAIL oor_pre_latency got %0d exp 5", lat); end
    run_op(2, 1'b0, 1'b1, 17'h01000, 8'h77, lat, q, e, b1, d2);
    n_vec++; if (e !== 1'b1) begin n_err++; $display("FAIL oor_wr_err got %b exp 1", e); end
    n_vec++; if (lat !== 5) begin n_err++; $display("FAIL oor_wr_latency got %0d exp 5", lat); end
    run_op(2, 1'b1, 1'b0, 17'h00000, 8'h00, lat, q, e, b1, d2);
    n_vec++; if (q !== 8'h5A) begin n_err++; $display("FAIL oor_alias got %h exp 5a", q); end
    n_vec++; if (e !== 1'b0) begin n_err++; $display("FAIL oor_inrange_err got %b exp 0", e); end
    run_op(2, 1'b1, 1'b0, 17'h01000, 8'h00, lat, q, e, b1, d2);
    n_vec++; if (q !== 8'h00) begin n_err++; $display("FAIL oor_rd_data got %h exp 00", q); end
    n_vec++; if (e !== 1'b1) begin n_err++; $display("FAIL oor_rd_err got %b exp 1", e); end
  endtask

  task automatic test_reset_mid;
    int lat; logic [7:0] q; logic e, b1, d2;
    run_op(0, 1'b0, 1'b1, 17'h00010, 8'h11, lat, q, e, b1, d2);
    @(negedge clk);
    wr_s[0] = 1'b1; addr_s[0] = 17'h00010; wd_s[0] = 8'hFF;
    @(negedge clk);
    wr_s[0] = 1'b0;
    n_vec++; if (busy_o[0] !== 1'b1) begin n_err++; $display("FAIL rstmid_in_wait got %b exp 1", busy_o[0]); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (busy_o[0] !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b exp 0", busy_o[0]); end
    n_vec++; if (done_o[0] !== 1'b0) begin n_err++; $display("FAIL rstmid_done got %b exp 0", done_o[0]); end
    n_vec++; if (rdata_o[0] !== 8'h00) begin n_err++; $display("FAIL rstmid_rdata got %h exp 00", rdata_o[0]); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 1'b1, 1'b0, 17'h00010, 8'h00, lat, q, e, b1, d2);
    n_vec++; if (q !== 8'h11) begin n_err++; $display("FAIL rstmid_ram got %h exp 11", q); end
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL rstmid_latency got %0d exp 4", lat); end
  endtask

  task automatic test_back_to_back;
    int lat; logic [7:0] q; logic e, b1, d2;
    int done_cyc [$];
    logic [7:0] got [$];
    run_op(0, 1'b0, 1'b1, 17'h00200, 8'h6B, lat, q, e, b1, d2);
    @(negedge clk);
    rd_s[0] = 1'b1; addr_s[0] = 17'h00200;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_o[0] === 1'b1) begin
        done_cyc.push_back(c);
        got.push_back(rdata_o[0]);
        $display("b2b done at cycle %0d rdata=%h", c, rdata_o[0]);
      end
    end
    rd_s[0] = 1'b0;
    repeat (8) @(negedge clk);
    n_vec++; if (done_cyc.size() !== 8) begin n_err++; $display("FAIL b2b_count got %0d exp 8", done_cyc.size()); end
    if (done_cyc.size() > 0) begin
      n_vec++; if (done_cyc[0] !== 3) begin n_err++; $display("FAIL b2b_first got %0d exp 3", done_cyc[0]); end
    end
    for (int i = 1; i < done_cyc.size(); i++) begin
      n_vec++; if (done_cyc[i] - done_cyc[i-1] !== 5) begin n_err++; $display("FAIL b2b_gap got %0d exp 5", done_cyc[i] - done_cyc[i-1]); end
    end
    foreach (got[i]) begin
      n_vec++; if (got[i] !== 8'h6B) begin n_err++; $display("FAIL b2b_data got %h exp 6b", got[i]); end
    end
  endtask

  task automatic test_random;
    logic [7:0] mem [int];
    logic [7:0] mrd [3];
    int lat, base, sel, key, exp_lat;
    logic [7:0] q, d, exp_q;
    logic e, b1, d2, rd, wr, exp_e;
    logic [16:0] a;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) mrd[k] = 8'h00;
    for (int k = 0; k < 3; k++) begin
      base = (k == 2) ? 0 : 4096 * k + 256;
      for (int i = 0; i < 16; i++) begin
        a = 17'(base + i); d = 8'($urandom);
        mem[k * 262144 + base + i] = d;
        run_op(k, 1'b0, 1'b1, a, d, lat, q, e, b1, d2);
        n_vec++; if (lat !== wait_k[k] + 2 || e !== 1'b0) begin n_err++; $display("FAIL rnd_fill inst=%0d lat=%0d err=%b exp lat=%0d err=0", k, lat, e, wait_k[k] + 2); end
      end
      for (int n = 0; n < 30; n++) begin
        sel = $urandom_range(0, 9);
        a = 17'(base + $urandom_range(0, 15)); d = 8'($urandom);
        case (sel)
          0, 1, 2, 3: begin rd = 1'b1; wr = 1'b0; end
          4, 5, 6, 7: begin rd = 1'b0; wr = 1'b1; end
          8:          begin rd = 1'b1; wr = 1'b1; end
          default: begin
            rd = 1'($urandom_range(0, 1)); wr = !rd;
            if (k == 2) a = 17'(4096 + $urandom_range(0, 15));
          end
        endcase
        exp_q = mrd[k];
        if (rd && wr) begin
          exp_lat = 1; exp_e = 1'b1;
        end else begin
          exp_lat = wait_k[k] + 2;
          exp_e = (int'(a) >= depth_k[k]);
          key = k * 262144 + int'(a);
          if (wr && !exp_e) mem[key] = d;
          if (rd) exp_q = exp_e ? 8'h00 : mem[key];
        end
        mrd[k] = exp_q;
        run_op(k, rd, wr, a, d, lat, q, e, b1, d2);
        n_vec++; if (lat !== exp_lat) begin n_err++; $display("FAIL rnd_latency inst=%0d got %0d exp %0d", k, lat, exp_lat); end
        n_vec++; if (e !== exp_e) begin n_err++; $display("FAIL rnd_err inst=%0d got %b exp %b", k, e, exp_e); end
        n_vec++; if (q !== exp_q) begin n_err++; $display("FAIL rnd_rdata inst=%0d addr=%h got %h exp %h", k, a, q, exp_q); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_wait();
    test_conflict();
    test_out_of_range();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before the scenarios completed");
    $fatal(1, "watchdog");
  end
endmodule
